// File: rtl/sap_core_param.sv
// sap_core_param -- parametrised SAP-style accumulator core.
//
// Purpose: fetch/execute core with a DW-bit datapath and a 2**AW word RAM.
// Registers exchange data over an internal one-hot AND-OR bus mux.
// A variable-length T-state sequencer runs each instruction. RAM is loaded
// through the program pins while prog_mode is high.
//
// Ports:
//   fastClk    system clock
//   rst        asynchronous reset, active low
//   clk_en     step enable; core state advances only on enabled edges
//   prog_mode  1 = hold core cleared and accept RAM writes, 0 = run
//   prog_we    RAM write strobe (only while prog_mode=1)
//   prog_addr  RAM program address
//   prog_data  RAM program data
//   out_data   output register
//   out_valid  one-cycle pulse after out_data is loaded
//   halted     core has executed HLT
//   pc_out     program counter
//   carry_flag carry flag (ADD carry / SUB no-borrow)
//   zero_flag  zero flag of last ADD/SUB result
module sap_core_param #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          fastClk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          prog_mode,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [DW-1:0] prog_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   output logic          halted,
   output logic [AW-1:0] pc_out,
   output logic          carry_flag,
   output logic          zero_flag
);

   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   // One-hot bus source indices
   localparam int SEL_PC   = 0;
   localparam int SEL_RAM  = 1;
   localparam int SEL_OPND = 2;
   localparam int SEL_A    = 3;
   localparam int SEL_ALU  = 4;
   localparam int NSRC     = 5;

   typedef enum logic [2:0] {T0, T1, T2, T3, T4} tstate_t;

   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] ram_q;

   tstate_t       t_reg, t_next;
   logic [AW-1:0] pc_reg, mar_reg, mar_next;
   logic [DW-1:0] ir_reg, a_reg, b_reg, out_reg;
   logic          out_valid_reg, halted_reg, carry_reg, zero_reg;

   logic [3:0]    opcode;
   logic [NSRC-1:0] bus_sel;
   logic [DW-1:0] bus_src [NSRC];
   logic [DW-1:0] bus_term [NSRC];
   logic [DW-1:0] bus;
   logic [DW:0]   alu;
   logic          advance, mar_load, ram_we;

   function automatic logic uses_mem(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
   endfunction

   // Opcodes 0 and 9..13 finish after fetch
   function automatic logic has_exec(input logic [3:0] op);
      return ((op >= 4'd1) && (op <= 4'd8)) || (op == OP_OUT) || (op == OP_HLT);
   endfunction

   assign advance = clk_en & ~prog_mode & ~halted_reg;
   assign opcode  = ir_reg[DW-1:DW-4];

   // Bus source select: exactly one source per T-state
   always_comb begin
      bus_sel = '0;
      case (t_reg)
         T0:      bus_sel[SEL_PC] = 1'b1;
         T1:      bus_sel[SEL_RAM] = 1'b1;
         T2:      if (opcode == OP_OUT) bus_sel[SEL_A] = 1'b1;
                  else                  bus_sel[SEL_OPND] = 1'b1;
         T3:      if (opcode == OP_STA) bus_sel[SEL_A] = 1'b1;
                  else                  bus_sel[SEL_RAM] = 1'b1;
         T4:      bus_sel[SEL_ALU] = 1'b1;
         default: bus_sel = '0;
      endcase
   end

   assign bus_src[SEL_PC]   = {{(DW-AW){1'b0}}, pc_reg};
   assign bus_src[SEL_RAM]  = ram_q;
   assign bus_src[SEL_OPND] = {{(DW-AW){1'b0}}, ir_reg[AW-1:0]};
   assign bus_src[SEL_A]    = a_reg;
   assign bus_src[SEL_ALU]  = alu[DW-1:0];

   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_bus
         assign bus_term[gi] = bus_src[gi] & {DW{bus_sel[gi]}};
      end
   endgenerate

   always_comb begin
      bus = '0;
      for (int i = 0; i < NSRC; i++) bus = bus | bus_term[i];
   end

   // SUB computes A + ~B + 1 so bit DW reads as "no borrow"
   always_comb begin
      if (opcode == OP_SUB) alu = {1'b0, a_reg} + {1'b0, ~b_reg} + {{DW{1'b0}}, 1'b1};
      else                  alu = {1'b0, a_reg} + {1'b0, b_reg};
   end

   always_comb begin
      t_next = T0;
      case (t_reg)
         T0:      t_next = T1;
         T1:      t_next = has_exec(bus[DW-1:DW-4]) ? T2 : T0;  // bus carries the fetched word
         T2:      t_next = uses_mem(opcode) ? T3 : T0;
         T3:      t_next = ((opcode == OP_ADD) || (opcode == OP_SUB)) ? T4 : T0;
         default: t_next = T0;
      endcase
   end

   // The RAM read is issued with the address MAR is about to take, so the
   // registered read data lines up with MAR in the following state.
   assign mar_load = advance && ((t_reg == T0) || ((t_reg == T2) && uses_mem(opcode)));
   assign mar_next = prog_mode ? '0 : (mar_load ? bus[AW-1:0] : mar_reg);
   assign ram_we   = advance && rst && (t_reg == T3) && (opcode == OP_STA);

   always_ff @(posedge fastClk) begin
      if (prog_mode && prog_we) ram[prog_addr] <= prog_data;
      else if (ram_we)          ram[mar_reg]   <= bus;
      ram_q <= ram[mar_next];
   end

   always_ff @(posedge fastClk or negedge rst) begin
      if (!rst) begin
         t_reg         <= T0;
         pc_reg        <= '0;
         mar_reg       <= '0;
         ir_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         halted_reg    <= 1'b0;
         carry_reg     <= 1'b0;
         zero_reg      <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         mar_reg       <= mar_next;
         if (prog_mode) begin
            t_reg      <= T0;
            pc_reg     <= '0;
            ir_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            out_reg    <= '0;
            halted_reg <= 1'b0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
         end else if (advance) begin
            t_reg <= t_next;
            case (t_reg)
               T1: begin
                  ir_reg <= bus;
                  pc_reg <= pc_reg + AW'(1);
               end
               T2: begin
                  case (opcode)
                     OP_LDI:  a_reg <= bus;
                     OP_JMP:  pc_reg <= bus[AW-1:0];
                     OP_JC:   if (carry_reg) pc_reg <= bus[AW-1:0];
                     OP_JZ:   if (zero_reg)  pc_reg <= bus[AW-1:0];
                     OP_OUT: begin
                        out_reg       <= bus;
                        out_valid_reg <= 1'b1;
                     end
                     OP_HLT:  halted_reg <= 1'b1;
                     default: ;
                  endcase
               end
               T3: begin
                  if (opcode == OP_LDA) a_reg <= bus;
                  else if ((opcode == OP_ADD) || (opcode == OP_SUB)) b_reg <= bus;
               end
               T4: begin
                  a_reg     <= bus;
                  carry_reg <= alu[DW];
                  zero_reg  <= (alu[DW-1:0] == '0);
               end
               default: ;
            endcase
         end
      end
   end

   assign out_data   = out_reg;
   assign out_valid  = out_valid_reg;
   assign halted     = halted_reg;
   assign pc_out     = pc_reg;
   assign carry_flag = carry_reg;
   assign zero_flag  = zero_reg;

endmodule

// File: tb/tb_sap_core_param.sv
// tb_sap_core_param -- directed self-checking bench for sap_core_param.
// Instance u1 uses DW=8/AW=4, instance u2 uses DW=12/AW=8; both share clk.
module tb_sap_core_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1, clk_en1, prog_mode1, prog_we1;
   logic [3:0] prog_addr1, pc1;
   logic [7:0] prog_data1, out1;
   logic       valid1, halted1, c1, z1;

   logic        rst2, clk_en2, prog_mode2, prog_we2;
   logic [7:0]  prog_addr2, pc2;
   logic [11:0] prog_data2, out2;
   logic        valid2, halted2, c2, z2;

   int n_cmp = 0;
   int n_err = 0;
   int pulses1 = 0;

   logic [7:0]  img1 [16];
   logic [11:0] img2 [256];

   sap_core_param #(.DW(8), .AW(4)) u1 (
      .fastClk(clk), .rst(rst1), .clk_en(clk_en1), .prog_mode(prog_mode1),
      .prog_we(prog_we1), .prog_addr(prog_addr1), .prog_data(prog_data1),
      .out_data(out1), .out_valid(valid1), .halted(halted1), .pc_out(pc1),
      .carry_flag(c1), .zero_flag(z1));

   sap_core_param #(.DW(12), .AW(8)) u2 (
      .fastClk(clk), .rst(rst2), .clk_en(clk_en2), .prog_mode(prog_mode2),
      .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
      .out_data(out2), .out_valid(valid2), .halted(halted2), .pc_out(pc2),
      .carry_flag(c2), .zero_flag(z2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
         $display("check %-14s ok     observed 0x%0h", tag, obs);
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear1();
      for (int a = 0; a < 16; a++) img1[a] = 8'h00;
   endtask

   task automatic load1();
      clk_en1    = 1'b1;
      prog_mode1 = 1'b1;
      for (int a = 0; a < 16; a++) begin
         prog_addr1 = 4'(a);
         prog_data1 = img1[a];
         prog_we1   = 1'b1;
         @(posedge clk); #1;
      end
      prog_we1   = 1'b0;
      prog_mode1 = 1'b0;
      pulses1    = 0;
   endtask

   task automatic run1(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (valid1) pulses1++;
      end
   endtask

   task automatic run2(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic load_sum();
      clear1();
      img1[0] = 8'h1E; img1[1] = 8'h2F; img1[2] = 8'hE0; img1[3] = 8'hF0;
      img1[14] = 8'h1C; img1[15] = 8'h0E;
      load1();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst1 = 1'b1; clk_en1 = 1'b1; prog_mode1 = 1'b1; prog_we1 = 1'b0;
      prog_addr1 = '0; prog_data1 = '0;
      rst2 = 1'b1; clk_en2 = 1'b1; prog_mode2 = 1'b1; prog_we2 = 1'b0;
      prog_addr2 = '0; prog_data2 = '0;

      // Asynchronous reset before any clock edge
      #2 rst1 = 1'b0; rst2 = 1'b0;
      #1;
      chk("rst_pc", pc1, 0);
      chk("rst_out", out1, 0);
      chk("rst_valid", valid1, 0);
      chk("rst_halted", halted1, 0);
      chk("rst_flags", {c1, z1}, 0);
      chk("rst_pc2", pc2, 0);
      @(posedge clk); #1;
      rst1 = 1'b1; rst2 = 1'b1;

      // Sum program: 28 + 14
      load_sum();
      run1(11);
      chk("sum_pre_valid", valid1, 0);
      chk("sum_pre_out", out1, 0);
      run1(1);
      chk("sum_out", out1, 8'h2A);
      chk("sum_valid", valid1, 1);
      run1(3);
      chk("sum_halted", halted1, 1);
      chk("sum_pc", pc1, 4);
      chk("sum_valid_off", valid1, 0);
      run1(4);
      chk("sum_hold_pc", pc1, 4);
      chk("sum_pulses", pulses1, 1);

      // Carry/zero: LDI/STA, 0xFF+0x01, JC and JZ taken
      clear1();
      img1[0] = 8'h5F; img1[1] = 8'h4D; img1[2] = 8'h1E; img1[3] = 8'h2F;
      img1[4] = 8'h7A; img1[6] = 8'hE0; img1[7] = 8'h1D; img1[8] = 8'hE0;
      img1[9] = 8'hF0; img1[10] = 8'h86; img1[14] = 8'hFF; img1[15] = 8'h01;
      load1();
      run1(16);
      chk("cz_flags", {c1, z1}, 2'b11);
      run1(3);
      chk("cz_jc_pc", pc1, 10);
      run1(3);
      chk("cz_jz_pc", pc1, 6);
      run1(3);
      chk("cz_out_valid", valid1, 1);
      chk("cz_out_zero", out1, 8'h00);
      run1(7);
      chk("cz_sta_lda", out1, 8'h0F);
      run1(3);
      chk("cz_halted", halted1, 1);
      chk("cz_end_pc", pc1, 10);
      chk("cz_flags_hold", {c1, z1}, 2'b11);

      // SUB 5-7 and not-taken JC at address 4
      clear1();
      img1[0] = 8'h55; img1[1] = 8'h3F; img1[2] = 8'hE0; img1[3] = 8'h00;
      img1[4] = 8'h79; img1[5] = 8'hE0; img1[6] = 8'hF0; img1[15] = 8'h07;
      load1();
      run1(8);
      chk("sub_flags", {c1, z1}, 2'b00);
      run1(3);
      chk("sub_out", out1, 8'hFE);
      run1(2);
      chk("nop_pc", pc1, 4);
      run1(3);
      chk("jc_nt_pc", pc1, 5);
      chk("jc_nt_flags", {c1, z1}, 2'b00);
      run1(3);
      chk("jc_nt_a", out1, 8'hFE);
      chk("jc_nt_valid", valid1, 1);
      run1(3);
      chk("sub_halted", halted1, 1);
      chk("sub_end_pc", pc1, 7);

      // PC wrap through a NOP at the top address
      clear1();
      img1[0] = 8'hE0; img1[1] = 8'h6F; img1[15] = 8'h00;
      load1();
      run1(6);
      chk("wrap_jmp_pc", pc1, 15);
      run1(2);
      chk("wrap_pc0", pc1, 0);
      run1(2);
      chk("wrap_fetch_pc", pc1, 1);
      run1(1);
      chk("wrap_out_valid", valid1, 1);

      // Sum program with clk_en high on one edge in four
      load_sum();
      for (int i = 0; i < 47; i++) begin
         clk_en1 = (i % 4 == 3);
         @(posedge clk); #1;
         if (valid1) pulses1++;
      end
      chk("stall_pre_out", out1, 0);
      chk("stall_pre_pls", pulses1, 0);
      clk_en1 = 1'b1;
      @(posedge clk); #1;
      if (valid1) pulses1++;
      chk("stall_out", out1, 8'h2A);
      chk("stall_valid", valid1, 1);
      for (int i = 48; i < 60; i++) begin
         clk_en1 = (i % 4 == 3);
         @(posedge clk); #1;
         if (valid1) pulses1++;
      end
      chk("stall_halted", halted1, 1);
      chk("stall_pc", pc1, 4);
      chk("stall_pulses", pulses1, 1);
      clk_en1 = 1'b1;

      // Async reset while halted, with a run-mode RAM write attempt
      prog_we1 = 1'b1; prog_addr1 = 4'd15; prog_data1 = 8'h50;
      rst1 = 1'b0;
      #1;
      chk("arst_out", out1, 0);
      chk("arst_halted", halted1, 0);
      chk("arst_pc", pc1, 0);
      @(posedge clk); #1;
      rst1 = 1'b1;
      run1(7);
      chk("mid_add_pc", pc1, 2);
      rst1 = 1'b0;
      #1;
      chk("mid_rst_pc", pc1, 0);
      @(posedge clk); #1;
      rst1 = 1'b1;
      pulses1 = 0;
      run1(12);
      chk("rerun_out", out1, 8'h2A);
      chk("rerun_pulses", pulses1, 1);
      run1(3);
      chk("rerun_halted", halted1, 1);
      prog_we1 = 1'b0;

      // DW=12 / AW=8: 0x1FF + 0x001, then JMP 200
      for (int a = 0; a < 256; a++) img2[a] = 12'h000;
      img2[0] = 12'h164; img2[1] = 12'h265; img2[2] = 12'hE00; img2[3] = 12'h6C8;
      img2[100] = 12'h1FF; img2[101] = 12'h001;
      img2[200] = 12'hE00; img2[201] = 12'hF00;
      prog_mode2 = 1'b1;
      for (int a = 0; a < 256; a++) begin
         prog_addr2 = 8'(a);
         prog_data2 = img2[a];
         prog_we2   = 1'b1;
         @(posedge clk); #1;
      end
      prog_we2   = 1'b0;
      prog_mode2 = 1'b0;
      run2(12);
      chk("w12_out", out2, 12'h200);
      chk("w12_valid", valid2, 1);
      chk("w12_flags", {c2, z2}, 2'b00);
      run2(3);
      chk("w12_jmp_pc", pc2, 200);
      run2(3);
      chk("w12_out2_vld", valid2, 1);
      run2(3);
      chk("w12_halted", halted2, 1);
      chk("w12_end_pc", pc2, 202);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
